beat_sequencer: RTL and testbench
=================================

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 Parameter SCORE_LEN, default 32: number of score entries; power of two, 2..256.
REQ-002 Parameter ADDR_W, default 5: score address width; SHALL equal log2(SCORE_LEN).
REQ-003 clk_in  input  1  system clock, 25 MHz.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 tick_in  input  1  one-cycle beat pulse from the beat divider, 4 Hz nominal.
REQ-006 start_in  input  1  one-cycle request to begin playback from address 0.
REQ-007 stop_in  input  1  one-cycle abort request.
REQ-008 note_out  output  5  current note code; 0 = silence.
REQ-009 note_valid  output  1  high while a score entry is sounding.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on natural end of score.
REQ-012 addr_out  output  ADDR_W  score address of the current entry.

Function
REQ-013 Score entry SHALL be 8 bits: [7:3] note code, [2:0] duration in ticks, with 0 meaning 8.
REQ-014 Note codes SHALL be: 0 rest, 1..21 tones (low/mid/high do..si), 31 end marker, 22..30 treated as rest.
REQ-015 The FSM SHALL have states IDLE, LOAD, PLAY and FINISH.
REQ-016 IDLE: on start_in SHALL set address to 0 and go to LOAD; tick_in SHALL be ignored.
REQ-017 LOAD: the synchronous ROM read SHALL have 1-cycle latency; the cycle after the address is presented, the entry SHALL be latched, the duration counter SHALL be loaded, and the FSM SHALL go to PLAY, or to FINISH if the note is 31.
REQ-018 A tick_in in a LOAD cycle SHALL be dropped and SHALL NOT count toward the new entry.
REQ-019 PLAY: note_out SHALL equal the latched note and note_valid = 1; each tick_in SHALL decrement the remaining count.
REQ-020 When the remaining count is 1 and tick_in = 1, the address SHALL increment (wrapping SCORE_LEN-1 -> 0) and the FSM SHALL go to LOAD.
REQ-021 Total entry duration SHALL be exactly D ticks, where D is the decoded duration.
REQ-022 LOAD SHALL last exactly 2 cycles (address present, data latch); note_out SHALL hold its previous value during LOAD.
REQ-023 FINISH: done SHALL pulse for one cycle, note_out = 0, note_valid = 0, then the FSM SHALL go to IDLE (see REQ-029).
REQ-024 stop_in in any non-IDLE state SHALL go to IDLE on the next edge: note_out = 0, note_valid = 0, no done pulse.
REQ-025 When start_in and stop_in are simultaneous, stop_in SHALL win; start_in outside IDLE SHALL be ignored.
REQ-026 Address wrap without an end marker SHALL continue playback indefinitely.

Reset
REQ-027 While rst_in = 1: state IDLE, note_out 0, note_valid 0, busy 0, done 0, addr_out 0, duration counter 0.
REQ-028 Reset asserted mid-playback SHALL abort immediately without a done pulse; after release, the block SHALL wait for start_in.

Configuration
REQ-029 Macro BEAT_SEQ_LOOP_EN:
- Defined: FINISH still pulses done, then sets address 0 and returns to LOAD, looping until stop_in.
- Undefined: FINISH -> IDLE.

Structure
REQ-030 Package beat_seq_pkg SHALL hold the note-code constants (REST, END_MARK=31), the entry field widths, the duration decode (0 -> 8) and the FSM state encoding.
REQ-031 Sub-module score_rom (synchronous read, 1-cycle latency, ADDR_W address, 8-bit data, contents from an init file) SHALL be instantiated once.

Verification
REQ-032 Score {0x0A (note 1, dur 2), 0x13 (note 2, dur 3), 0xF8 (end)}; start, 6 ticks -> note_out 1 for 2 ticks, then 2 for 3 ticks; done pulses once; busy drops; addr_out 2 at done.
REQ-033 Entry with duration field 0 -> note held exactly 8 ticks.
REQ-034 stop_in during the second note -> next cycle note_out 0, busy 0, no done; subsequent ticks cause no change.
REQ-035 start_in and stop_in in the same cycle while IDLE -> remains IDLE; tick_in in a LOAD cycle -> not counted, entry lasts its full D ticks after LOAD.
REQ-036 With BEAT_SEQ_LOOP_EN defined, end marker reached -> done pulses, note 1 replays from address 0; score with no end marker -> address wraps 31 -> 0.
REQ-037 rst_in asserted mid-note and released -> all outputs 0 while asserted; start_in after release plays from address 0.

Source files
------------

// File: rtl/beat_seq_pkg.sv
// Shared definitions for the beat sequencer: score entry layout, note codes,
// duration decode and FSM state encoding.
package beat_seq_pkg;

    localparam int ENTRY_W = 8;
    localparam int NOTE_W  = 5;
    localparam int DUR_W   = 3;
    localparam int CNT_W   = 4;

    localparam logic [NOTE_W-1:0]  REST        = 5'd0;
    localparam logic [NOTE_W-1:0]  TONE_MAX    = 5'd21;
    localparam logic [NOTE_W-1:0]  END_MARK    = 5'd31;
    localparam logic [ENTRY_W-1:0] BLANK_ENTRY = {END_MARK, 3'd0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_FINISH
    } state_t;

    // A zero duration field encodes the longest note, 8 ticks.
    function automatic logic [CNT_W-1:0] decode_dur(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? CNT_W'(8) : {1'b0, dur};
    endfunction

    // Codes above the tone range (other than the end marker) sound as rests.
    function automatic logic [NOTE_W-1:0] sounding_note(input logic [NOTE_W-1:0] code);
        return (code > TONE_MAX) ? REST : code;
    endfunction

endpackage

// File: rtl/score_rom.sv
// Score ROM with synchronous read (one cycle latency). mem is preloaded from the
// score init file by the build flow; locations not loaded read as end markers.
module score_rom
    import beat_seq_pkg::*;
#(
    parameter int SCORE_LEN = 32,
    parameter int ADDR_W    = 5
) (
    input  logic               clk_in,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] data
);

    logic [ENTRY_W-1:0] mem [SCORE_LEN] = '{default: BLANK_ENTRY};

    always_ff @(posedge clk_in) begin
        data <= mem[addr];
    end

endmodule

// File: rtl/beat_sequencer.sv
// Beat sequencer: plays a score entry by entry, advancing on beat ticks.
// Optional BEAT_SEQ_LOOP_EN: after the end marker, restart from address 0.
module beat_sequencer
    import beat_seq_pkg::*;
#(
    parameter int SCORE_LEN = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              tick_in,
    input  logic              start_in,
    input  logic              stop_in,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_out
);

    state_t             state_q, state_d;
    logic               load_ph_q, load_ph_d;  // 0: address presented, 1: entry on rom_data
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [ENTRY_W-1:0] rom_data;
    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;

    score_rom #(
        .SCORE_LEN(SCORE_LEN),
        .ADDR_W   (ADDR_W)
    ) u_rom (
        .clk_in(clk_in),
        .addr  (addr_q),
        .data  (rom_data)
    );

    assign rom_note = rom_data[ENTRY_W-1 -: NOTE_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            load_ph_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            note_q    <= REST;
        end else begin
            load_ph_q <= load_ph_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            note_q    <= note_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_ph_d = 1'b0;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        note_d    = note_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in && !stop_in) begin
                    addr_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (stop_in) begin
                    state_d = ST_IDLE;
                    note_d  = REST;
                    cnt_d   = '0;
                end else if (!load_ph_q) begin
                    load_ph_d = 1'b1;
                end else if (rom_note == END_MARK) begin
                    state_d = ST_FINISH;
                    note_d  = REST;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_PLAY;
                    note_d  = sounding_note(rom_note);
                    cnt_d   = decode_dur(rom_dur);
                end
            end
            ST_PLAY: begin
                if (stop_in) begin
                    state_d = ST_IDLE;
                    note_d  = REST;
                    cnt_d   = '0;
                end else if (tick_in) begin
                    cnt_d = cnt_q - 1'b1;
                    // Last tick of the entry: move on; the address wraps naturally.
                    if (cnt_q == CNT_W'(1)) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_FINISH: begin
                note_d = REST;
                if (stop_in) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef BEAT_SEQ_LOOP_EN
                    addr_d  = '0;
                    state_d = ST_LOAD;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign note_out   = note_q;
    assign note_valid = (state_q == ST_PLAY);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign addr_out   = addr_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: a score-level model predicts the sequence
// of sounded entries and done pulses; a monitor compares them as the DUT plays.
`timescale 1ns/1ps
module tb_beat_sequencer;

    localparam int SCORE_LEN = 32;
    localparam int ADDR_W    = 5;
    localparam int MAX_CYC   = 4000;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              tick_in = 1'b0;
    logic              start_in = 1'b0;
    logic              stop_in = 1'b0;
    logic [4:0]        note_out;
    logic              note_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr_out;

    always #20 clk_in = ~clk_in;

    beat_sequencer #(.SCORE_LEN(SCORE_LEN), .ADDR_W(ADDR_W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .tick_in   (tick_in),
        .start_in  (start_in),
        .stop_in   (stop_in),
        .note_out  (note_out),
        .note_valid(note_valid),
        .busy      (busy),
        .done      (done),
        .addr_out  (addr_out)
    );

    typedef struct {
        bit is_done;
        int note;
        int addr;
        int ticks;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] score [SCORE_LEN];
    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic pop_check(input bit is_done, input int note, input int addr, input int ticks);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: done=%0d note=%0d addr=%0d ticks=%0d, required none",
                     is_done, note, addr, ticks);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind_is_done", int'(is_done), int'(e.is_done));
        check(is_done ? "done_addr" : "seg_addr", addr, e.addr);
        if (is_done) begin
            check("done_note", note, 0);
        end else begin
            check("seg_note", note, e.note);
            check("seg_ticks", ticks, e.ticks);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit prev_valid = 1'b0;
        bit seg_stable = 1'b1;
        int seg_note = 0;
        int seg_addr = 0;
        int seg_ticks = 0;
        forever begin
            @(negedge clk_in);
            if (done) done_cnt++;
            if (!mon_en) begin
                prev_valid = 1'b0;
            end else begin
                if (note_valid) begin
                    if (!prev_valid) begin
                        seg_note   = int'(note_out);
                        seg_addr   = int'(addr_out);
                        seg_ticks  = 0;
                        seg_stable = 1'b1;
                    end else if (int'(note_out) != seg_note || int'(addr_out) != seg_addr) begin
                        seg_stable = 1'b0;
                    end
                    if (tick_in) seg_ticks++;
                end else if (prev_valid) begin
                    pop_check(1'b0, seg_note, seg_addr, seg_ticks);
                    check("seg_note_addr_stable", int'(seg_stable), 1);
                end
                if (done) begin
                    pop_check(1'b1, int'(note_out), int'(addr_out), 0);
                    check("done_note_valid", int'(note_valid), 0);
                end
                prev_valid = note_valid;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic fill_score(input logic [7:0] val);
        for (int i = 0; i < SCORE_LEN; i++) score[i] = val;
    endtask

    task automatic load_rom();
        for (int i = 0; i < SCORE_LEN; i++) dut.u_rom.mem[i] = score[i];
    endtask

    // Score-level model: walk entries from address 0; returns 1 if playback ends on its own.
    function automatic bit build_expected(input int max_ev);
        int  a = 0;
        int  n = 0;
        int  code;
        int  dur;
        ev_t e;
        logic [7:0] ent;
        while (n < max_ev) begin
            ent  = score[a];
            code = int'(ent[7:3]);
            dur  = (ent[2:0] == 3'd0) ? 8 : int'(ent[2:0]);
            if (code == 31) begin
                e.is_done = 1'b1; e.note = 0; e.addr = a; e.ticks = 0;
                exp_q.push_back(e);
                n++;
`ifdef BEAT_SEQ_LOOP_EN
                a = 0;
`else
                return 1'b1;
`endif
            end else begin
                e.is_done = 1'b0; e.note = (code <= 21) ? code : 0; e.addr = a; e.ticks = dur;
                exp_q.push_back(e);
                n++;
                a = (a + 1) % SCORE_LEN;
            end
        end
        return 1'b0;
    endfunction

    // tick_mode 0: random tick spacing; 1: tick every cycle (hits every LOAD cycle).
    task automatic run_score(input int max_ev, input int tick_mode);
        bit ended;
        int budget = 0;
        int gap = 0;
        load_rom();
        ended  = build_expected(max_ev);
        mon_en = 1'b1;
        start_in = 1'b1;
        tick_in  = (tick_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        cyc();
        start_in = 1'b0;
        while (exp_q.size() != 0 && budget < MAX_CYC) begin
            if (tick_mode == 1) begin
                tick_in = 1'b1;
            end else if (gap == 0) begin
                tick_in = 1'b1;
                gap = $urandom_range(0, 3);
            end else begin
                tick_in = 1'b0;
                gap--;
            end
            cyc();
            budget++;
        end
        tick_in = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        if (!ended) begin
            stop_in = 1'b1;
            cyc();
            stop_in = 1'b0;
        end
        cyc();
        cyc();
        check("end_busy", int'(busy), 0);
        check("end_note_valid", int'(note_valid), 0);
        check("end_note_out", int'(note_out), 0);
        mon_en = 1'b0;
    endtask

    task automatic wait_note2(input string name);
        int n = 0;
        start_in = 1'b1;
        cyc();
        start_in = 1'b0;
        while (!(note_valid && note_out == 5'd2) && n < 200) begin
            tick_in = (n % 2 == 0);
            cyc();
            n++;
        end
        tick_in = 1'b0;
        check(name, int'(note_out), 2);
    endtask

    initial begin
        #(90000 * 40);
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [4:0] c5;
        logic [2:0] d3;
        int endpos;

        // Reset state
        cyc();
        cyc();
        check("rst_note_out", int'(note_out), 0);
        check("rst_note_valid", int'(note_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr_out", int'(addr_out), 0);
        rst_in = 1'b0;
        cyc();

        // start and stop together while idle: stop wins
        start_in = 1'b1;
        stop_in  = 1'b1;
        cyc();
        start_in = 1'b0;
        stop_in  = 1'b0;
        check("startstop_busy", int'(busy), 0);
        cyc();
        cyc();
        check("startstop_busy_later", int'(busy), 0);

        // Reference score: note 1 for 2 ticks, note 2 for 3 ticks, end
        fill_score(8'hF8);
        score[0] = 8'h0A;
        score[1] = 8'h13;
        score[2] = 8'hF8;
        d0 = done_cnt;
        run_score(10, 0);
`ifndef BEAT_SEQ_LOOP_EN
        check("ref_done_once", done_cnt - d0, 1);
`endif

        // Duration field 0 holds for 8 ticks; ticks every cycle, including LOAD cycles
        fill_score(8'hF8);
        score[0] = 8'h08;
        score[1] = 8'hF8;
        run_score(6, 1);

        // stop during the second note
        fill_score(8'hF8);
        score[0] = 8'h0A;
        score[1] = 8'h13;
        score[2] = 8'hF8;
        load_rom();
        wait_note2("stop_reach_note2");
        stop_in = 1'b1;
        cyc();
        stop_in = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_note_out", int'(note_out), 0);
        check("stop_note_valid", int'(note_valid), 0);
        d0 = done_cnt;
        repeat (6) begin
            tick_in = 1'b1;
            cyc();
        end
        tick_in = 1'b0;
        cyc();
        check("stop_idle_busy", int'(busy), 0);
        check("stop_idle_note_out", int'(note_out), 0);
        check("stop_no_done", done_cnt, d0);

        // Reset in the middle of the second note
        wait_note2("rst_reach_note2");
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("midrst_note_out", int'(note_out), 0);
        check("midrst_note_valid", int'(note_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_addr_out", int'(addr_out), 0);
        tick_in = 1'b1;
        cyc();
        cyc();
        check("midrst_held_busy", int'(busy), 0);
        rst_in = 1'b0;
        repeat (4) cyc();
        tick_in = 1'b0;
        check("postrst_busy", int'(busy), 0);
        check("postrst_addr_out", int'(addr_out), 0);
        run_score(10, 0);

        // Random scores with an end marker
        for (int r = 0; r < 6; r++) begin
            endpos = $urandom_range(1, 10);
            for (int i = 0; i < SCORE_LEN; i++) begin
                c5 = 5'($urandom_range(0, 30));
                d3 = 3'($urandom_range(0, 7));
                score[i] = {c5, d3};
            end
            score[endpos] = 8'hF8;
            run_score(30, 0);
        end

        // No end marker: playback wraps past the last address
        for (int i = 0; i < SCORE_LEN; i++) begin
            c5 = 5'($urandom_range(0, 30));
            d3 = 3'($urandom_range(0, 7));
            score[i] = {c5, d3};
        end
        run_score(40, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
